// File: rtl/pmu_pkg.sv
// Shared types and defaults for the PMU operand sequencer.
package pmu_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

  localparam int NUM_LANES  = 240;
  localparam int DATA_WIDTH = 16;
  localparam int OUT_W      = DATA_WIDTH + 1;

  // Bit offset of lane idx in a flat bus of w-bit lanes.
  function automatic int lane_lsb(int idx, int w);
    return idx * w;
  endfunction

  function automatic logic [31:0] sat_inc32(logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pmu_lane_mux.sv
// Registered NUM_LANES:1 selector of one PMU result lane.
module pmu_lane_mux
  import pmu_pkg::*;
#(
  parameter int NUM_LANES = pmu_pkg::NUM_LANES,
  parameter int W         = pmu_pkg::OUT_W,
  parameter int IDX_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [IDX_W-1:0]       sel,
  input  logic [NUM_LANES*W-1:0] p_flat,
  output logic [W-1:0]           q
);

  logic [W-1:0] lanes [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lanes[g] = p_flat[lane_lsb(g, W) +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= lanes[sel];
  end

endmodule

// File: rtl/pmu_seq_ctrl.sv
// PMU operand loader / result streamer.
// Optional PMU_SEQ_PERF_EN adds the batch_cycles performance counter.
module pmu_seq_ctrl #(
  parameter int NUM_LANES  = pmu_pkg::NUM_LANES,
  parameter int DATA_WIDTH = pmu_pkg::DATA_WIDTH,
  parameter int PMU_LAT    = 2,
  parameter int IDX_W      = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_a,
  input  logic [DATA_WIDTH-1:0]             in_b,
  input  logic                              in_last,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   A_flat,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   B_flat,
  input  logic [NUM_LANES*(DATA_WIDTH+1)-1:0] P_flat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH:0]               out_data,
  output logic [IDX_W-1:0]                  out_idx,
  output logic                              out_last,
  output logic                              busy
`ifdef PMU_SEQ_PERF_EN
  ,output logic [31:0]                      batch_cycles
`endif
);
  import pmu_pkg::*;

  localparam int OW = DATA_WIDTH + 1;

  state_t                                  state;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    a_q, b_q;
  logic [IDX_W-1:0]                        wr_idx, rd_idx, nxt_idx, mux_sel;
  logic [IDX_W:0]                          count;
  logic [3:0]                              wcnt;
  logic                                    hs_in, fin, mux_en;

  assign A_flat  = a_q;
  assign B_flat  = b_q;
  assign hs_in   = in_valid & in_ready & ((state == IDLE) | (state == LOAD));
  assign fin     = in_last | (wr_idx == IDX_W'(NUM_LANES - 1));
  assign nxt_idx = rd_idx + IDX_W'(1);
  assign mux_en  = ((state == WAIT) && (wcnt == 4'(PMU_LAT))) ||
                   ((state == DRAIN) && out_ready && !out_last);
  assign mux_sel = (state == WAIT) ? '0 : nxt_idx;

  pmu_lane_mux #(.NUM_LANES(NUM_LANES), .W(OW), .IDX_W(IDX_W)) u_mux (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mux_en),
    .sel    (mux_sel),
    .p_flat (P_flat),
    .q      (out_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      count     <= '0;
      wcnt      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (state == IDLE) in_ready <= 1'b1;
          if (hs_in) begin
            // Write this lane; on the final pair also clear stale lanes above it.
            for (int i = 0; i < NUM_LANES; i++) begin
              if (i == int'(wr_idx)) begin
                a_q[i] <= in_a;
                b_q[i] <= in_b;
              end else if (fin && (i > int'(wr_idx))) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
              end
            end
            busy <= 1'b1;
            if (fin) begin
              state    <= WAIT;
              count    <= {1'b0, wr_idx} + (IDX_W+1)'(1);
              wr_idx   <= '0;
              wcnt     <= '0;
              in_ready <= 1'b0;
            end else begin
              state  <= LOAD;
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        WAIT: begin
          // One settle cycle plus the PMU pipeline depth.
          if (wcnt == 4'(PMU_LAT)) begin
            state     <= DRAIN;
            rd_idx    <= '0;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= (count == (IDX_W+1)'(1));
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              rd_idx   <= nxt_idx;
              out_idx  <= nxt_idx;
              out_last <= ({1'b0, nxt_idx} + (IDX_W+1)'(1)) == count;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PMU_SEQ_PERF_EN
  logic [31:0] perf_cnt;
  logic        perf_run, hs_last;

  assign hs_last = (state == DRAIN) & out_ready & out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt     <= '0;
      perf_run     <= 1'b0;
      batch_cycles <= '0;
    end else begin
      if (hs_in && (state == IDLE)) begin
        perf_cnt <= 32'd1;
        perf_run <= 1'b1;
      end else if (perf_run) begin
        perf_cnt <= sat_inc32(perf_cnt);
      end
      if (hs_last) begin
        batch_cycles <= sat_inc32(perf_cnt);
        perf_run     <= 1'b0;
      end
    end
  end
`endif

endmodule
